// File: rtl/seqgen_1011_tx.sv
// Serial frame transmitter: sync pattern 1011, then payload MSB first, then a zero guard gap.
// Valid/ready input; one word per frame, no queueing.
module seqgen_1011_tx #(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = (DATA_W > 4) ? ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN)
                                        : ((GAP_LEN > 4) ? GAP_LEN : 4);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dout_q, dout_d;
  logic                dout_en_q, dout_en_d;
  logic                frame_done_q, frame_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // cnt_q holds the number of bits of the current state already placed on dout
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_en_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_SYNC;
          sreg_d    = tx_data;
          dout_d    = 1'b1;
          dout_en_d = 1'b1;
          cnt_d     = CNT_W'(1);
        end
      end
      ST_SYNC: begin
        dout_en_d = 1'b1;
        if (cnt_q == CNT_W'(4)) begin
          state_d      = ST_DATA;
          dout_d       = sreg_q[DATA_W-1];
          sreg_d       = sreg_q << 1;
          cnt_d        = CNT_W'(1);
          frame_done_d = (DATA_W == 1);
        end else begin
          // remaining sync bits after the leading 1 are 0,1,1
          dout_d = (cnt_q != CNT_W'(1));
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          sreg_d = '0;
          if (GAP_LEN > 0) begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          dout_en_d    = 1'b1;
          dout_d       = sreg_q[DATA_W-1];
          sreg_d       = sreg_q << 1;
          cnt_d        = cnt_q + CNT_W'(1);
          frame_done_d = (cnt_q == CNT_W'(DATA_W - 1));
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_LEN)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dout       = dout_q;
  assign dout_en    = dout_en_q;
  assign frame_done = frame_done_q;

endmodule
